// File: rtl/muldiv_hilo_if.sv
// -----------------------------------------------------------------------------
// muldiv_hilo_if
// Bundle between the EX stage and the multiply/divide HiLo sequencer.
//   start       EX holds a valid mul/div op this cycle
//   op          3'b000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB
//   a, b        rs / rt operands after forwarding
//   hilo_req    EX holds MFHI/MFLO this cycle
//   flush       synchronous cancel of the in-flight op
//   hilo_read   current {Hi,Lo}, consumed by MADD/MSUB only
//   busy        operation in flight
//   stall       freeze IF/ID/EX
//   hilo_en     one-cycle HiLo write strobe
//   hilo_write  {Hi,Lo} write data
//   done        one-cycle completion pulse, coincident with hilo_en
//   div_by_zero one-cycle pulse with hilo_en when the divisor was 0
// master = EX side, slave = sequencer.
// -----------------------------------------------------------------------------
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [2:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 hilo_req;
    logic                 flush;
    logic [2*WIDTH-1:0]   hilo_read;
    logic                 busy;
    logic                 stall;
    logic                 hilo_en;
    logic [2*WIDTH-1:0]   hilo_write;
    logic                 done;
    logic                 div_by_zero;

    modport master (
        output start, op, a, b, hilo_req, flush, hilo_read,
        input  busy, stall, hilo_en, hilo_write, done, div_by_zero
    );

    modport slave (
        input  start, op, a, b, hilo_req, flush, hilo_read,
        output busy, stall, hilo_en, hilo_write, done, div_by_zero
    );
endinterface

// File: rtl/muldiv_hilo_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_hilo_sequencer
// Radix-2 multi-cycle multiply/divide unit that owns every write to HiLo.
// States IDLE -> MUL/DIV (WIDTH cycles) -> FIX (sign correction) -> WRITE.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_hilo_if.slave (see interface file for signal list)
// Optional feature macro: MULDIV_ACCUM_EN enables MADD/MSUB (op 100/101),
// which add/subtract the signed product to/from HiLo sampled at start.
// -----------------------------------------------------------------------------
module muldiv_hilo_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    muldiv_hilo_if.slave     bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DIV   = 3'd2,
        FIX   = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t               state_r, state_n;
    logic [CW-1:0]        count_r;
    logic [WIDTH-1:0]     mag_a_r, mag_b_r, a_orig_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic                 is_div_r, neg_res_r, neg_rem_r, dbz_r;
    logic [2*WIDTH-1:0]   hilo_write_r;
    logic                 hilo_en_r, done_r, dbz_out_r;

    logic                 op_valid_s, op_signed_s, op_div_s, op_acc_s, op_sub_s;
    logic                 accept_s, b_zero_s, sign_a_s, sign_b_s;
    logic [WIDTH-1:0]     mag_a_in_s, mag_b_in_s;
    logic [WIDTH:0]       mul_sum_s, div_shift_s, div_diff_s;
    logic                 div_fits_s;
    logic [2*WIDTH-1:0]   prod_s, fix_result_s;
    logic [WIDTH-1:0]     quo_s, rem_s;

`ifdef MULDIV_ACCUM_EN
    logic [2*WIDTH-1:0]   base_r;
    logic                 acc_op_r, sub_op_r;
`else
    logic                 unused_hilo_read_s;
    assign unused_hilo_read_s = ^bus.hilo_read;
`endif

    // Opcode decode: validity, signedness, divide and accumulate flavours
    always_comb begin
        op_valid_s  = 1'b0;
        op_signed_s = 1'b0;
        op_div_s    = 1'b0;
        op_acc_s    = 1'b0;
        op_sub_s    = 1'b0;
        case (bus.op)
            3'b000: begin op_valid_s = 1'b1; op_signed_s = 1'b1; end
            3'b001: begin op_valid_s = 1'b1; end
            3'b010: begin op_valid_s = 1'b1; op_signed_s = 1'b1; op_div_s = 1'b1; end
            3'b011: begin op_valid_s = 1'b1; op_div_s = 1'b1; end
`ifdef MULDIV_ACCUM_EN
            3'b100: begin op_valid_s = 1'b1; op_signed_s = 1'b1; op_acc_s = 1'b1; end
            3'b101: begin op_valid_s = 1'b1; op_signed_s = 1'b1; op_acc_s = 1'b1; op_sub_s = 1'b1; end
`endif
            default: begin
                op_valid_s = 1'b0;
            end
        endcase
    end

    assign accept_s   = bus.start & op_valid_s & ~bus.flush;
    assign b_zero_s   = (bus.b == {WIDTH{1'b0}});
    assign sign_a_s   = op_signed_s & bus.a[WIDTH-1];
    assign sign_b_s   = op_signed_s & bus.b[WIDTH-1];
    assign mag_a_in_s = sign_a_s ? ({WIDTH{1'b0}} - bus.a) : bus.a;
    assign mag_b_in_s = sign_b_s ? ({WIDTH{1'b0}} - bus.b) : bus.b;

    // Shift-add step: the upper half accumulates, product bits shift into the lower half
    assign mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                         {1'b0, (mag_b_r[0] ? mag_a_r : {WIDTH{1'b0}})};
    // Restoring-divide step: remainder lives in the upper half, quotient bits enter the lower half
    assign div_shift_s = {acc_r[2*WIDTH-1:WIDTH], mag_a_r[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, mag_b_r};
    assign div_fits_s  = ~div_diff_s[WIDTH];

    assign quo_s  = acc_r[WIDTH-1:0];
    assign rem_s  = acc_r[2*WIDTH-1:WIDTH];
    assign prod_s = neg_res_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;

    // Sign correction of the magnitude result, divide-by-zero override and accumulate
    always_comb begin
        fix_result_s = prod_s;
        if (dbz_r) begin
            fix_result_s = {a_orig_r, {WIDTH{1'b1}}};
        end else if (is_div_r) begin
            fix_result_s = {(neg_rem_r ? ({WIDTH{1'b0}} - rem_s) : rem_s),
                            (neg_res_r ? ({WIDTH{1'b0}} - quo_s) : quo_s)};
        end else begin
`ifdef MULDIV_ACCUM_EN
            if (acc_op_r) begin
                fix_result_s = sub_op_r ? (base_r - prod_s) : (base_r + prod_s);
            end else begin
                fix_result_s = prod_s;
            end
`else
            fix_result_s = prod_s;
`endif
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic; flush cancels everything except the WRITE already committed
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (op_div_s) begin
                        state_n = b_zero_s ? FIX : DIV;
                    end else begin
                        state_n = MUL;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            MUL, DIV: begin
                if (bus.flush) begin
                    state_n = IDLE;
                end else if (count_r == LAST) begin
                    state_n = FIX;
                end else begin
                    state_n = state_r;
                end
            end
            FIX: begin
                if (bus.flush) begin
                    state_n = IDLE;
                end else begin
                    state_n = WRITE;
                end
            end
            WRITE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r      <= {CW{1'b0}};
            mag_a_r      <= {WIDTH{1'b0}};
            mag_b_r      <= {WIDTH{1'b0}};
            a_orig_r     <= {WIDTH{1'b0}};
            acc_r        <= {(2*WIDTH){1'b0}};
            is_div_r     <= 1'b0;
            neg_res_r    <= 1'b0;
            neg_rem_r    <= 1'b0;
            dbz_r        <= 1'b0;
            hilo_write_r <= {(2*WIDTH){1'b0}};
            hilo_en_r    <= 1'b0;
            done_r       <= 1'b0;
            dbz_out_r    <= 1'b0;
`ifdef MULDIV_ACCUM_EN
            base_r       <= {(2*WIDTH){1'b0}};
            acc_op_r     <= 1'b0;
            sub_op_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        count_r   <= {CW{1'b0}};
                        mag_a_r   <= mag_a_in_s;
                        mag_b_r   <= mag_b_in_s;
                        a_orig_r  <= bus.a;
                        acc_r     <= {(2*WIDTH){1'b0}};
                        is_div_r  <= op_div_s;
                        neg_res_r <= sign_a_s ^ sign_b_s;
                        neg_rem_r <= sign_a_s;
                        dbz_r     <= op_div_s & b_zero_s;
`ifdef MULDIV_ACCUM_EN
                        base_r    <= bus.hilo_read;
                        acc_op_r  <= op_acc_s;
                        sub_op_r  <= op_sub_s;
`endif
                    end else begin
                        count_r <= count_r;
                    end
                end
                MUL: begin
                    acc_r   <= {mul_sum_s, acc_r[WIDTH-1:1]};
                    mag_b_r <= {1'b0, mag_b_r[WIDTH-1:1]};
                    count_r <= count_r + CW'(1'b1);
                end
                DIV: begin
                    acc_r   <= {(div_fits_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0]),
                                acc_r[WIDTH-2:0], div_fits_s};
                    mag_a_r <= {mag_a_r[WIDTH-2:0], 1'b0};
                    count_r <= count_r + CW'(1'b1);
                end
                FIX: begin
                    if (!bus.flush) begin
                        hilo_write_r <= fix_result_s;
                        hilo_en_r    <= 1'b1;
                        done_r       <= 1'b1;
                        dbz_out_r    <= dbz_r;
                    end else begin
                        hilo_en_r    <= 1'b0;
                        done_r       <= 1'b0;
                        dbz_out_r    <= 1'b0;
                    end
                end
                WRITE: begin
                    hilo_en_r <= 1'b0;
                    done_r    <= 1'b0;
                    dbz_out_r <= 1'b0;
                end
                default: begin
                    hilo_en_r <= 1'b0;
                    done_r    <= 1'b0;
                    dbz_out_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = (state_r != IDLE);
    assign bus.stall       = bus.busy & (bus.start | bus.hilo_req);
    assign bus.hilo_en     = hilo_en_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_out_r;
    assign bus.hilo_write  = hilo_write_r;
endmodule

// File: doc/muldiv_hilo_sequencer.md
Name: muldiv_hilo_sequencer

Overview:
- Multi-cycle multiply/divide controller that owns all writes to the EX-stage HiLo register pair.
- Accepts one MULT/MULTU/DIV/DIVU operation at a time from EX.
- Iterates radix-2 (one bit per cycle), applies sign correction and issues a single 64-bit HiLo write.
- Raises Stall toward the hazard unit when EX issues another mul/div or an MFHI/MFLO while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HiLo width is 2*WIDTH; iteration count equals WIDTH.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  EX holds a valid mul/div op this cycle
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB; other codes ignored
- A  in  WIDTH  rs operand (multiplicand/dividend), post-forwarding
- B  in  WIDTH  rt operand (multiplier/divisor), post-forwarding
- HiLoReq  in  1  EX holds MFHI/MFLO this cycle
- Flush  in  1  synchronous cancel of the in-flight op
- HiLoRead  in  2*WIDTH  current HiLo contents ({Hi,Lo}), used by MADD/MSUB
- Busy  out  1  operation in flight
- Stall  out  1  freeze IF/ID/EX
- HiLoEn  out  1  one-cycle HiLo write strobe
- HiLoWrite  out  2*WIDTH  {Hi,Lo} write data
- Done  out  1  one-cycle pulse, coincident with HiLoEn
- DivByZero  out  1  one-cycle pulse with HiLoEn when divisor was 0

Behaviour:
- Reset low: state IDLE, counter 0, all internal registers 0, all outputs 0. Takes effect immediately, including mid-operation; no HiLo write is issued.
- States: IDLE, MUL, DIV, FIX, WRITE.
- IDLE to MUL/DIV: on an edge with Start=1, a valid Op and Flush=0.
  - Latch the sign flags and the magnitudes |A| and |B|. Signed ops use two's-complement magnitude; unsigned ops use the raw operands.
  - Clear the 2*WIDTH accumulator and set count=0.
  - Start with an invalid Op is ignored and the state stays IDLE.
- MUL: shift-add, one multiplier bit per cycle. Leaves after WIDTH cycles (count==WIDTH-1) for FIX.
- DIV: restoring divide, one quotient bit per cycle. Leaves after WIDTH cycles for FIX.
  - Divisor 0 skips the iteration and goes directly to FIX with the DivByZero flag set.
- FIX (1 cycle), sign correction:
  - Product is negated if the operand signs differ (signed ops).
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Divide by zero: Lo = all ones, Hi = A (original operand).
  - DIV 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0 (result of the magnitude method; no trap).
- WRITE (1 cycle): HiLoEn=1, Done=1, HiLoWrite = {Hi,Lo}, DivByZero as flagged. The next state is always IDLE.
- Latency: the Start edge is cycle 0, HiLoEn is high in cycle WIDTH+2 (34), and the op can be re-accepted in cycle WIDTH+3.
- Busy = (state != IDLE).
- Stall = Busy & (Start | HiLoReq), combinational.
  - WRITE counts as busy, so an MFHI issued during WRITE stalls one cycle and reads the updated HiLo afterwards.
  - Stall is never asserted in IDLE.
- A Start while Busy is not accepted; the held instruction is accepted on the first edge in IDLE.
- Flush=1 while Busy: next edge goes to IDLE and no HiLoEn is issued. Flush=1 in IDLE also blocks acceptance of Start that cycle.
- Flush and WRITE in the same cycle: the write still commits, because the instruction has already left EX.
- HiLoWrite holds its last value when HiLoEn=0 and is 0 after reset.

Optional Feature:
- Macro: MULDIV_ACCUM_EN.
- Defined: Op 100 (MADD) and 101 (MSUB) are valid signed ops.
  - HiLoRead is sampled on the Start edge.
  - In FIX the corrected product is added to or subtracted from it, modulo 2^(2*WIDTH).
- Not defined: Op 100/101 are treated as invalid and ignored; HiLoRead is unused.

Test Plan:
- MULT A=0xFFFFFFFE, B=3: HiLoEn exactly 34 cycles after Start, HiLoWrite = 0xFFFFFFFF_FFFFFFFA, Done=1, DivByZero=0.
- MULTU A=B=0xFFFFFFFF: HiLoWrite = 0xFFFFFFFE_00000001.
- DIV A=0xFFFFFFF9 (-7), B=2: Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF. DIVU 7/2: Lo = 3, Hi = 1.
- DIVU A=0x1234, B=0: HiLoWrite = 0x00001234_FFFFFFFF, DivByZero pulses with HiLoEn.
- HiLoReq held from cycle 5 of an in-flight MULT: Stall=1 through the WRITE cycle, then 0 in IDLE. A back-to-back Start is accepted on the first IDLE edge.
- Flush in cycle 10 of a DIV: Busy=0 next cycle, no HiLoEn. Reset pulled low in cycle 20 of another op: all outputs 0 immediately.
